// File: rtl/reg_writeback_pkg.sv
// Shared types for the register write-back slice: destination selector and
// memory write buffer states.
package types;

    typedef enum logic [4:0] {
        REG_A,
        REG_B,
        REG_TEMPA,
        REG_TEMPB,
        REG_XL,
        REG_XH,
        REG_XP,
        REG_YL,
        REG_YH,
        REG_YP,
        REG_SPL,
        REG_SPH,
        REG_MX,
        REG_MY,
        REG_MSP,
        REG_MN,
        REG_ALU,
        REG_IMM,
        REG_HARDCODED_1
    } reg_type;

    typedef enum logic {
        BUF_IDLE,
        BUF_PEND
    } buf_state_t;

    function automatic logic is_mem_dest(reg_type d);
        return (d == REG_MX) || (d == REG_MY) || (d == REG_MSP) || (d == REG_MN);
    endfunction

    function automatic logic is_x_dest(reg_type d);
        return (d == REG_XL) || (d == REG_XH) || (d == REG_XP);
    endfunction

    function automatic logic is_y_dest(reg_type d);
        return (d == REG_YL) || (d == REG_YH) || (d == REG_YP);
    endfunction

    function automatic logic is_sp_dest(reg_type d);
        return (d == REG_SPL) || (d == REG_SPH);
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Single-beat RAM write bus with a ready handshake.
interface reg_writeback_if;

    logic        mem_write_en;
    logic [11:0] mem_write_addr;
    logic [3:0]  mem_write_data;
    logic        mem_ready;

    modport master (
        output mem_write_en,
        output mem_write_addr,
        output mem_write_data,
        input  mem_ready
    );

    modport slave (
        input  mem_write_en,
        input  mem_write_addr,
        input  mem_write_data,
        output mem_ready
    );

endinterface

// File: rtl/reg_writeback_buffer.sv
// Single-entry buffered RAM write: holds one request until mem_ready accepts it.
module mem_write_buffer
    import types::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [11:0]              capture_addr,
    input  logic [3:0]               capture_data,
    output logic                     stall,
    reg_writeback_if.master          mem
);

    buf_state_t  state, state_next;
    logic [11:0] addr_reg;
    logic [3:0]  data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BUF_IDLE;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_reg <= capture_addr;
                data_reg <= capture_data;
            end
        end
    end

    // A capture can only arrive when not stalled, so it may overlap a completion.
    always_comb begin
        state_next = state;
        unique case (state)
            BUF_IDLE: if (capture) state_next = BUF_PEND;
            BUF_PEND: if (mem.mem_ready && !capture) state_next = BUF_IDLE;
            default:  state_next = BUF_IDLE;
        endcase
    end

    assign mem.mem_write_en   = (state == BUF_PEND);
    assign mem.mem_write_addr = addr_reg;
    assign mem.mem_write_data = data_reg;
    assign stall              = (state == BUF_PEND) && !mem.mem_ready;

endmodule

// File: rtl/reg_writeback.sv
// Architectural register file write-back: register loads, index/SP adjusts and
// buffered memory-destination writes.
module reg_writeback
    import types::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            write_en,
    input  reg_type         dest,
    input  logic [3:0]      data,
    input  logic [3:0]      immed,
    input  logic            x_inc,
    input  logic            y_inc,
    input  logic            sp_inc,
    input  logic            sp_dec,
    output logic [3:0]      a,
    output logic [3:0]      b,
    output logic [3:0]      temp_a,
    output logic [3:0]      temp_b,
    output logic [11:0]     x,
    output logic [11:0]     y,
    output logic [7:0]      sp,
    output logic            stall,
    reg_writeback_if.master mem
);

    logic        accept;
    logic        wr_x, wr_y, wr_sp;
    logic        capture;
    logic [11:0] capture_addr;

    assign accept  = write_en && !stall;
    assign wr_x    = write_en && is_x_dest(dest);
    assign wr_y    = write_en && is_y_dest(dest);
    assign wr_sp   = write_en && is_sp_dest(dest);
    assign capture = accept && is_mem_dest(dest);

    // Address uses the pre-adjust register values of this cycle.
    always_comb begin
        capture_addr = '0;
        case (dest)
            REG_MX:  capture_addr = x;
            REG_MY:  capture_addr = y;
            REG_MSP: capture_addr = {4'h0, sp};
            REG_MN:  capture_addr = {8'h00, immed};
            default: capture_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            temp_a <= '0;
            temp_b <= '0;
            x      <= '0;
            y      <= '0;
            sp     <= '0;
        end else if (!stall) begin
            // An explicit write to a register suppresses its adjust this cycle.
            if (x_inc && !wr_x) x[7:0] <= x[7:0] + 8'd1;
            if (y_inc && !wr_y) y[7:0] <= y[7:0] + 8'd1;
            if (!wr_sp && sp_inc && !sp_dec) sp <= sp + 8'd1;
            if (!wr_sp && sp_dec && !sp_inc) sp <= sp - 8'd1;
            if (write_en) begin
                case (dest)
                    REG_A:     a       <= data;
                    REG_B:     b       <= data;
                    REG_TEMPA: temp_a  <= data;
                    REG_TEMPB: temp_b  <= data;
                    REG_XL:    x[3:0]  <= data;
                    REG_XH:    x[7:4]  <= data;
                    REG_XP:    x[11:8] <= data;
                    REG_YL:    y[3:0]  <= data;
                    REG_YH:    y[7:4]  <= data;
                    REG_YP:    y[11:8] <= data;
                    REG_SPL:   sp[3:0] <= data;
                    REG_SPH:   sp[7:4] <= data;
                    default:   ;
                endcase
            end
        end
    end

    mem_write_buffer u_buf (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .capture_addr (capture_addr),
        .capture_data (data),
        .stall        (stall),
        .mem          (mem)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Directed and randomized checks of reg_writeback against a behavioural model.
module tb_reg_writeback;
    import types::*;

    logic        clk = 0;
    logic        reset;
    logic        write_en;
    reg_type     dest;
    logic [3:0]  data, immed;
    logic        x_inc, y_inc, sp_inc, sp_dec;
    logic [3:0]  a, b, temp_a, temp_b;
    logic [11:0] x, y;
    logic [7:0]  sp;
    logic        stall;

    reg_writeback_if mem_if ();

    reg_writeback dut (
        .clk     (clk),
        .reset   (reset),
        .write_en(write_en),
        .dest    (dest),
        .data    (data),
        .immed   (immed),
        .x_inc   (x_inc),
        .y_inc   (y_inc),
        .sp_inc  (sp_inc),
        .sp_dec  (sp_dec),
        .a       (a),
        .b       (b),
        .temp_a  (temp_a),
        .temp_b  (temp_b),
        .x       (x),
        .y       (y),
        .sp      (sp),
        .stall   (stall),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [3:0]  m_a, m_b, m_ta, m_tb;
    logic [11:0] m_x, m_y, n_x, n_y;
    logic [7:0]  m_sp, n_sp;
    logic        m_pend;
    logic [11:0] m_addr;
    logic [3:0]  m_data;
    bit          wx, wy, wsp;

    initial begin
        m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; m_x = 0; m_y = 0; m_sp = 0;
        m_pend = 0; m_addr = 0; m_data = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; m_x = 0; m_y = 0; m_sp = 0;
            m_pend = 0; m_addr = 0; m_data = 0;
        end else if (!(m_pend && !mem_if.mem_ready)) begin
            n_x = m_x; n_y = m_y; n_sp = m_sp;
            wx  = write_en && (dest == REG_XL || dest == REG_XH || dest == REG_XP);
            wy  = write_en && (dest == REG_YL || dest == REG_YH || dest == REG_YP);
            wsp = write_en && (dest == REG_SPL || dest == REG_SPH);
            // Not stalled: any pending write completes at this edge.
            m_pend = 0;
            if (x_inc && !wx) n_x = (m_x & 12'hF00) | ((m_x + 12'd1) & 12'h0FF);
            if (y_inc && !wy) n_y = (m_y & 12'hF00) | ((m_y + 12'd1) & 12'h0FF);
            if (!wsp) n_sp = m_sp + 8'(sp_inc) - 8'(sp_dec);
            if (write_en) begin
                case (dest)
                    REG_A:     m_a  = data;
                    REG_B:     m_b  = data;
                    REG_TEMPA: m_ta = data;
                    REG_TEMPB: m_tb = data;
                    REG_XL:    n_x  = (m_x & 12'hFF0) | 12'(data);
                    REG_XH:    n_x  = (m_x & 12'hF0F) | (12'(data) << 4);
                    REG_XP:    n_x  = (m_x & 12'h0FF) | (12'(data) << 8);
                    REG_YL:    n_y  = (m_y & 12'hFF0) | 12'(data);
                    REG_YH:    n_y  = (m_y & 12'hF0F) | (12'(data) << 4);
                    REG_YP:    n_y  = (m_y & 12'h0FF) | (12'(data) << 8);
                    REG_SPL:   n_sp = (m_sp & 8'hF0) | 8'(data);
                    REG_SPH:   n_sp = (m_sp & 8'h0F) | (8'(data) << 4);
                    REG_MX:    begin m_pend = 1; m_addr = m_x; m_data = data; end
                    REG_MY:    begin m_pend = 1; m_addr = m_y; m_data = data; end
                    REG_MSP:   begin m_pend = 1; m_addr = 12'(m_sp); m_data = data; end
                    REG_MN:    begin m_pend = 1; m_addr = 12'(immed); m_data = data; end
                    default:   ;
                endcase
            end
            m_x = n_x; m_y = n_y; m_sp = n_sp;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_a", a, m_a);
            check("m_b", b, m_b);
            check("m_temp_a", temp_a, m_ta);
            check("m_temp_b", temp_b, m_tb);
            check("m_x", x, m_x);
            check("m_y", y, m_y);
            check("m_sp", sp, m_sp);
            check("m_mem_en", mem_if.mem_write_en, m_pend);
            check("m_stall", stall, m_pend && !mem_if.mem_ready);
            if (m_pend) begin
                check("m_mem_addr", mem_if.mem_write_addr, m_addr);
                check("m_mem_data", mem_if.mem_write_data, m_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input reg_type d, input logic [3:0] v);
        write_en = 1; dest = d; data = v;
        cyc();
        write_en = 0;
    endtask

    initial begin
        reset = 1; write_en = 0; dest = REG_A; data = 0; immed = 0;
        x_inc = 0; y_inc = 0; sp_inc = 0; sp_dec = 0; mem_if.mem_ready = 1;
        cyc();
        model_on = 1;
        cyc();
        reset = 0;
        check("rst_a", a, 0);
        check("rst_x", x, 0);
        check("rst_sp", sp, 0);
        check("rst_mem_en", mem_if.mem_write_en, 0);
        check("rst_stall", stall, 0);

        wr(REG_A, 4'h7);
        check("a_7", a, 4'h7);
        wr(REG_SPH, 4'hC);
        check("sp_c0", sp, 8'hC0);
        check("b_0", b, 0);
        check("x_0", x, 0);

        wr(REG_XP, 4'h3); wr(REG_XH, 4'hF); wr(REG_XL, 4'hF);
        check("x_3ff", x, 12'h3FF);
        x_inc = 1;
        wr(REG_MX, 4'h5);
        x_inc = 0;
        check("mx_en", mem_if.mem_write_en, 1);
        check("mx_addr", mem_if.mem_write_addr, 12'h3FF);
        check("mx_data", mem_if.mem_write_data, 4'h5);
        check("x_wrap", x, 12'h300);
        cyc();
        check("mx_done", mem_if.mem_write_en, 0);

        wr(REG_SPH, 4'h0); wr(REG_SPL, 4'h0);
        sp_dec = 1; cyc(); sp_dec = 0;
        check("sp_ff", sp, 8'hFF);
        sp_inc = 1; wr(REG_SPL, 4'h2); sp_inc = 0;
        check("sp_f2", sp, 8'hF2);

        mem_if.mem_ready = 0; immed = 4'hA;
        wr(REG_MN, 4'h9);
        write_en = 1; dest = REG_A; data = 4'hE;
        for (int i = 0; i < 3; i++) begin
            check("mn_stall", stall, 1);
            check("mn_addr", mem_if.mem_write_addr, 12'h00A);
            check("mn_hold_a", a, 4'h7);
            if (i < 2) cyc();
        end
        mem_if.mem_ready = 1;
        #1;
        check("mn_ready_stall", stall, 0);
        cyc();
        write_en = 0;
        check("mn_done", mem_if.mem_write_en, 0);
        check("a_e", a, 4'hE);

        wr(REG_YL, 4'h4);
        wr(REG_MY, 4'h1);
        check("my_addr", mem_if.mem_write_addr, 12'h004);
        check("my_stall", stall, 0);
        wr(REG_MSP, 4'h2);
        check("msp_en", mem_if.mem_write_en, 1);
        check("msp_addr", mem_if.mem_write_addr, 12'h0F2);
        check("msp_data", mem_if.mem_write_data, 4'h2);
        cyc();
        check("b2b_done", mem_if.mem_write_en, 0);

        wr(REG_IMM, 4'hF); wr(REG_ALU, 4'hF);
        check("imm_a", a, 4'hE);
        check("imm_en", mem_if.mem_write_en, 0);

        mem_if.mem_ready = 0;
        wr(REG_MX, 4'h3);
        check("pend_en", mem_if.mem_write_en, 1);
        reset = 1; cyc(); reset = 0;
        check("rst_pend_en", mem_if.mem_write_en, 0);
        check("rst_pend_stall", stall, 0);

        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            write_en = ($urandom_range(0, 3) != 0);
            dest     = reg_type'($urandom_range(0, 18));
            data     = 4'($urandom);
            immed    = 4'($urandom);
            x_inc    = ($urandom_range(0, 3) == 0);
            y_inc    = ($urandom_range(0, 3) == 0);
            sp_inc   = ($urandom_range(0, 3) == 0);
            sp_dec   = ($urandom_range(0, 3) == 0);
            mem_if.mem_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        reset = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Destination-side counterpart to the CPU register source mux. Holds the architectural registers A, B, TEMPA, TEMPB, X, Y and SP, and applies microcode write-backs selected by a `reg_type` destination. Writes to memory destinations (MX, MY, MSP, Mn) go through a single-entry buffered write request toward RAM, using a ready handshake. It also performs the post-increment of X and Y and the SP push/pop adjust. Its register outputs feed the source mux directly.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `write_en`  in  1  apply a write-back this cycle.
- `dest`  in  `reg_type`  destination selector.
- `data`  in  4  nibble to write.
- `immed`  in  4  Mn address nibble.
- `x_inc`  in  1  increment X[7:0].
- `y_inc`  in  1  increment Y[7:0].
- `sp_inc`  in  1  SP + 1 (pop).
- `sp_dec`  in  1  SP − 1 (push).
- `mem_ready`  in  1  RAM accepts the presented write.
- `a`, `b`, `temp_a`, `temp_b`  out  4 each  register values.
- `x`, `y`  out  12 each  index registers.
- `sp`  out  8  stack pointer.
- `mem_write_en`  out  1  write request valid.
- `mem_write_addr`  out  12  write address.
- `mem_write_data`  out  4  write data.
- `stall`  out  1  a buffered memory write is pending and unaccepted.

## Operation
- All updates are registered.
- When `write_en`=1 and `stall`=0, `dest` selects the target:
  - A, B, TEMPA, TEMPB: load `data`.
  - XL, XH, XP: load `data` into x[3:0], x[7:4] or x[11:8]. YL, YH, YP: same on y.
  - SPL, SPH: load `data` into sp[3:0] or sp[7:4].
  - MX, MY, MSP, Mn: capture a memory write into the buffer.
  - ALU, IMM, HARDCODED_1: not writable; ignored with no state change.
- Memory write address:
  - MX uses x; MY uses y; MSP uses {4'h0, sp}; Mn uses {8'h00, immed}.
  - The address is always the pre-adjust value from the same cycle.
- Index increment:
  - `x_inc`: x[7:0] ← x[7:0] + 1, wrapping FF→00; x[11:8] unchanged.
  - `y_inc`: identical on y.
- SP adjust:
  - `sp_inc`: sp ← sp + 1; `sp_dec`: sp ← sp − 1; 8-bit wrap.
  - Both asserted: no change.
- Same-cycle priority: an explicit write to any nibble of x, y or sp beats that register's inc/dec; the inc/dec is dropped for that cycle. Other registers' adjusts still apply.
- Buffer states (two-state FSM, IDLE and PEND):
  - IDLE → PEND on an accepted memory-destination write.
  - PEND → IDLE when `mem_ready`=1.
- While `stall`=1, all inputs (`write_en`, inc, dec) are ignored. Upstream must hold them.

## Timing
- Register write: the new value appears on its output the cycle after `write_en`.
- Memory write:
  - `mem_write_en` rises the cycle after capture.
  - `mem_write_addr`/`mem_write_data` are stable while `mem_write_en` is high.
  - The transfer completes in a cycle where `mem_write_en`=1 and `mem_ready`=1.
- `stall` = PEND && !`mem_ready` (combinational). With `mem_ready` tied high, back-to-back memory writes sustain one per cycle. In that case a capture in the same cycle as a completion moves the FSM PEND → PEND.
- Reset:
  - All registers 0, `mem_write_en`=0, `stall`=0, FSM IDLE.
  - A pending memory write is discarded on reset.

## Structure
- `reg_type` and its enumerators stay in package `types`.
- One sub-module is natural: `mem_write_buffer`, holding the PEND flag, address/data registers and the ready handshake.
- Register update logic lives in the top level as a single clocked process.

## Test plan
- Reset, then write A=4'h7 and SPH=4'hC → next cycle `a`=7, `sp`=8'hC0. All other outputs remain 0.
- x=12'h3FF, dest=MX, data=5, `x_inc` in the same cycle → write addr 12'h3FF, data 5; afterwards x=12'h300.
- sp=8'h00 with `sp_dec` → sp=8'hFF. Then SPL write of 4'h2 together with `sp_inc` → sp=8'hF2 (write wins).
- Mn write with immed=4'hA and `mem_ready` low for 3 cycles:
  - addr 12'h00A is held and `stall`=1 for 3 cycles.
  - A concurrent A write is ignored.
  - The request completes on the cycle `mem_ready` rises.
- With `mem_ready`=1, MY then MSP on consecutive cycles → two consecutive `mem_write_en` cycles with the correct addresses; `stall` is never high.
- dest=REG_IMM or REG_ALU with `write_en` → no output changes and no `mem_write_en`.
- Reset asserted while in PEND → `mem_write_en`=0 on the next cycle; the FSM returns to IDLE.
